// File: rtl/cellram_pkg.sv
// Shared types and constants for the CellularRAM asynchronous-mode controller.
package cellram_pkg;

    localparam int unsigned ADDR_W        = 23;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned T_ACCESS_DEF  = 7;
    localparam int unsigned T_RECOVER_DEF = 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold,
        StRecover
    } state_e;

endpackage

// File: rtl/cellram_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; sets the length of ACCESS and RECOVER.
module cellram_wait_counter
    import cellram_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cellram_ctrl.sv
// Single-word asynchronous-mode CellularRAM controller with a valid/ready request port.
// Optional completed-access statistics counters: define CELLRAM_CTRL_STATS_EN.
module cellram_ctrl #(
    parameter int unsigned T_ACCESS  = cellram_pkg::T_ACCESS_DEF,
    parameter int unsigned T_RECOVER = cellram_pkg::T_RECOVER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [22:0] ram_a,
    input  logic [15:0] ram_dq_i,
    output logic [15:0] ram_dq_o,
    output logic        ram_dq_oe,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        ram_lb_n,
    output logic        ram_ub_n,
    output logic        ram_adv_n,
    output logic [31:0] stat_rd_count,
    output logic [31:0] stat_wr_count
);
    import cellram_pkg::*;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]    cnt_load_val;
    logic                busy, hold;

    cellram_wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                // Counter counts T_ACCESS-1 down to 0, giving T_ACCESS cycles in ACCESS.
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(T_ACCESS - 1);
                state_d      = StAccess;
            end
            StAccess: begin
                if (cnt_zero) begin
                    if (!we_q) begin
                        rdata_d = ram_dq_i;
                    end
                    state_d = StHold;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StHold: begin
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(T_RECOVER - 1);
                state_d      = StRecover;
            end
            StRecover: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy      = (state_q == StSetup) || (state_q == StAccess) || (state_q == StHold);
    assign hold      = (state_q == StHold);
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = hold && !we_q;
    assign rsp_rdata = rdata_q;
    assign ram_a     = addr_q;
    assign ram_dq_o  = wdata_q;
    assign ram_dq_oe = busy && we_q;
    assign ram_ce_n  = !busy;
    assign ram_oe_n  = !((state_q == StAccess) && !we_q);
    assign ram_we_n  = !((state_q == StAccess) && we_q);
    assign ram_lb_n  = busy ? (we_q ? !be_q[0] : 1'b0) : 1'b1;
    assign ram_ub_n  = busy ? (we_q ? !be_q[1] : 1'b0) : 1'b1;
    assign ram_adv_n = 1'b0;

`ifdef CELLRAM_CTRL_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (hold && !we_q) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (hold && we_q) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd_count = rd_cnt_q;
    assign stat_wr_count = wr_cnt_q;
`else
    assign stat_rd_count = '0;
    assign stat_wr_count = '0;
`endif

endmodule

// File: tb/tb_cellram_ctrl.sv
// Bench for cellram_ctrl: instance 0 uses default timing, instance 1 uses T_ACCESS=1/T_RECOVER=15.
module tb_cellram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [22:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be    [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic [22:0] ram_a     [2];
    logic [15:0] ram_dq_i  [2];
    logic [15:0] ram_dq_o  [2];
    logic        ram_dq_oe [2];
    logic        ram_ce_n  [2];
    logic        ram_oe_n  [2];
    logic        ram_we_n  [2];
    logic        ram_lb_n  [2];
    logic        ram_ub_n  [2];
    logic        ram_adv_n [2];
    logic [31:0] stat_rd   [2];
    logic [31:0] stat_wr   [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cellram_ctrl #(
            .T_ACCESS  ((g == 0) ? 7 : 1),
            .T_RECOVER ((g == 0) ? 1 : 15)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_we        (req_we[g]),
            .req_addr      (req_addr[g]),
            .req_wdata     (req_wdata[g]),
            .req_be        (req_be[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_rdata     (rsp_rdata[g]),
            .ram_a         (ram_a[g]),
            .ram_dq_i      (ram_dq_i[g]),
            .ram_dq_o      (ram_dq_o[g]),
            .ram_dq_oe     (ram_dq_oe[g]),
            .ram_ce_n      (ram_ce_n[g]),
            .ram_oe_n      (ram_oe_n[g]),
            .ram_we_n      (ram_we_n[g]),
            .ram_lb_n      (ram_lb_n[g]),
            .ram_ub_n      (ram_ub_n[g]),
            .ram_adv_n     (ram_adv_n[g]),
            .stat_rd_count (stat_rd[g]),
            .stat_wr_count (stat_wr[g])
        );
    end

    // Behavioural RAM shared by both controllers; data bus only driven while oe_n is low.
    logic [15:0] mem [int];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ram_ce_n[i] && !ram_we_n[i]) begin
                logic [15:0] w;
                w = mem.exists(int'(ram_a[i])) ? mem[int'(ram_a[i])] : 16'h0;
                if (!ram_lb_n[i]) w[7:0] = ram_dq_o[i][7:0];
                if (!ram_ub_n[i]) w[15:8] = ram_dq_o[i][15:8];
                mem[int'(ram_a[i])] = w;
            end
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ram_dq_i[i] <= (!ram_oe_n[i] && mem.exists(int'(ram_a[i]))) ? mem[int'(ram_a[i])] :
                           (!ram_oe_n[i] ? 16'h0 : 16'hDEAD);
        end
    end

    // Reference model state.
    logic [15:0] ref_mem [int];
    logic [15:0] last_rd [2];
    int          exp_rdc [2];
    int          exp_wrc [2];

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic ref_wr(input int a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] w;
        w = ref_rd(a);
        if (be[0]) w[7:0] = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        ref_mem[a] = w;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [8:0] ctl(input int u);
        return {ram_ce_n[u], ram_oe_n[u], ram_we_n[u], ram_lb_n[u], ram_ub_n[u],
                ram_adv_n[u], ram_dq_oe[u], rsp_valid[u], req_ready[u]};
    endfunction

    task automatic chk_stats(input string name);
`ifdef CELLRAM_CTRL_STATS_EN
        for (int u = 0; u < 2; u++) begin
            chk({name, "_rd"}, 64'(stat_rd[u]), 64'(exp_rdc[u]));
            chk({name, "_wr"}, 64'(stat_wr[u]), 64'(exp_wrc[u]));
        end
`else
        for (int u = 0; u < 2; u++) begin
            chk({name, "_rd_off"}, 64'(stat_rd[u]), 64'd0);
            chk({name, "_wr_off"}, 64'(stat_wr[u]), 64'd0);
        end
`endif
    endtask

    // One access, entered and left at a negedge with the controller idle.
    // Cycle 0 is the handshake cycle; expected strobes per cycle follow from the phase lengths.
    task automatic access(input int u, input logic we, input logic [22:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input logic [15:0] exp_rd);
        int ta, per;
        logic setup, acc, hold, busy;
        logic [8:0] exp;
        ta  = (u == 0) ? 7 : 1;
        per = 3 + ta + ((u == 0) ? 1 : 15);
        chk("ready_idle", 64'(req_ready[u]), 64'd1);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        req_be[u]    = be;
        for (int k = 1; k <= per; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid[u] = 1'($urandom_range(0, 1));
                req_we[u]    = 1'($urandom);
                req_addr[u]  = 23'($urandom);
                req_wdata[u] = 16'($urandom);
                req_be[u]    = 2'($urandom);
            end
            setup = (k == 1);
            acc   = (k >= 2) && (k <= 1 + ta);
            hold  = (k == 2 + ta);
            busy  = setup || acc || hold;
            exp   = {!busy, !(acc && !we), !(acc && we),
                     busy ? (we ? !be[0] : 1'b0) : 1'b1,
                     busy ? (we ? !be[1] : 1'b0) : 1'b1,
                     1'b0, busy && we, hold && !we, k == per};
            chk($sformatf("ctl_u%0d_k%0d", u, k), 64'(ctl(u)), 64'(exp));
            if (busy) chk("ram_a", 64'(ram_a[u]), 64'(addr));
            if (busy && we) chk("dq_o", 64'(ram_dq_o[u]), 64'(wdata));
            if (hold && !we) begin
                chk("rdata", 64'(rsp_rdata[u]), 64'(exp_rd));
                last_rd[u] = exp_rd;
            end
        end
        chk("rdata_hold", 64'(rsp_rdata[u]), 64'(last_rd[u]));
        req_valid[u] = 1'b0;
        if (we) exp_wrc[u]++;
        else    exp_rdc[u]++;
    endtask

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 23'h000123, 16'hBEEF, 2'b11, 16'h0000};
        vt[1] = '{1'b0, 23'h000123, 16'h0000, 2'b00, 16'hBEEF};
        vt[2] = '{1'b1, 23'h7FFFFF, 16'h1234, 2'b10, 16'h0000};
        vt[3] = '{1'b0, 23'h7FFFFF, 16'h0000, 2'b11, 16'h1200};
        vt[4] = '{1'b1, 23'h7FFFFF, 16'hAB56, 2'b01, 16'h0000};
        vt[5] = '{1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'h1256};
        vt[6] = '{1'b1, 23'h7FFFFF, 16'hFFFF, 2'b00, 16'h0000};
        vt[7] = '{1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'h1256};

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            req_be[u]    = '0;
            last_rd[u]   = '0;
            exp_rdc[u]   = 0;
            exp_wrc[u]   = 0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_ctl", 64'(ctl(u)), 64'(9'b111110001));
            chk("reset_a", 64'(ram_a[u]), 64'd0);
            chk("reset_dq_o", 64'(ram_dq_o[u]), 64'd0);
            chk("reset_rdata", 64'(rsp_rdata[u]), 64'd0);
        end
        chk_stats("reset_stats");
        reset = 1'b0;
        @(negedge clk);

        // Directed table on the default-timing instance.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].we) ref_wr(int'(vt[i].addr), vt[i].wdata, vt[i].be);
            access(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].exp_rd);
        end

        // Randomized traffic over a small address window against the reference memory.
        for (int n = 0; n < 40; n++) begin
            int          u, a;
            logic        we;
            logic [15:0] d, e;
            logic [1:0]  be;
            u  = (n < 30) ? 0 : 1;
            we = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 15));
            d  = 16'($urandom);
            be = 2'($urandom);
            e  = ref_rd(a);
            if (we) ref_wr(a, d, be);
            access(u, we, 23'(a), d, be, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk_stats("stats_after_random");

        // Continuous req_valid with alternating read/write: acceptances one period apart.
        begin
            int acc_cyc [$];
            int lim;
            logic wr, prev_ce;
            wr = 1'b0;
            prev_ce = ram_ce_n[0];
            lim = 0;
            req_valid[0] = 1'b1;
            while (acc_cyc.size() < 4 && lim < 100) begin
                if (req_ready[0]) begin
                    chk("b2b_ce_gap", 64'(prev_ce), 64'd1);
                    acc_cyc.push_back(cyc);
                    req_we[0]    = wr;
                    req_addr[0]  = 23'(5 + acc_cyc.size());
                    req_wdata[0] = 16'($urandom);
                    req_be[0]    = 2'b11;
                    if (wr) begin
                        ref_wr(int'(req_addr[0]), req_wdata[0], 2'b11);
                        exp_wrc[0]++;
                    end else begin
                        last_rd[0] = ref_rd(int'(req_addr[0]));
                        exp_rdc[0]++;
                    end
                    wr = !wr;
                end
                prev_ce = ram_ce_n[0];
                @(negedge clk);
                lim++;
            end
            req_valid[0] = 1'b0;
            chk("b2b_accept_count", 64'(acc_cyc.size()), 64'd4);
            for (int i = 1; i < acc_cyc.size(); i++) begin
                chk("b2b_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd11);
            end
            repeat (12) @(negedge clk);
            chk("b2b_rdata", 64'(rsp_rdata[0]), 64'(last_rd[0]));
        end
        chk_stats("stats_after_b2b");

        // Reset in cycle 4 of a write aborts it without a response or count.
        begin
            int pulses;
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 23'h400000;
            req_wdata[0] = 16'h5A5A;
            req_be[0]    = 2'b11;
            @(negedge clk);
            req_valid[0] = 1'b0;
            repeat (3) @(negedge clk);
            chk("midwrite_we_low", 64'(ram_we_n[0]), 64'd0);
            reset = 1'b1;
            @(negedge clk);
            chk("abort_ctl", 64'(ctl(0)), 64'(9'b111110001));
            chk("abort_a", 64'(ram_a[0]), 64'd0);
            chk("abort_dq_o", 64'(ram_dq_o[0]), 64'd0);
            chk("abort_rdata", 64'(rsp_rdata[0]), 64'd0);
            reset = 1'b0;
            for (int u = 0; u < 2; u++) begin
                exp_rdc[u] = 0;
                exp_wrc[u] = 0;
                last_rd[u] = '0;
            end
            chk_stats("abort_stats");
            pulses = 0;
            repeat (12) begin
                @(negedge clk);
                if (rsp_valid[0]) pulses++;
            end
            chk("abort_no_rsp", 64'(pulses), 64'd0);
            chk_stats("abort_stats_later");
        end

        // Three reads and two writes after reset for the statistics counters.
        access(0, 1'b0, 23'h000123, 16'h0, 2'b00, ref_rd(32'h123));
        access(0, 1'b1, 23'h000009, 16'hC0DE, 2'b11, 16'h0);
        ref_wr(9, 16'hC0DE, 2'b11);
        access(1, 1'b0, 23'h000009, 16'h0, 2'b00, 16'hC0DE);
        access(1, 1'b1, 23'h00000A, 16'h7777, 2'b01, 16'h0);
        ref_wr(10, 16'h7777, 2'b01);
        access(0, 1'b0, 23'h00000A, 16'h0, 2'b00, ref_rd(10));
        chk_stats("stats_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cellram_ctrl.md
CELLRAM_CTRL -- requirements
Module: cellram_ctrl

Interface
REQ-001 SHALL have parameter T_ACCESS, default 7: cycles strobe (oe_n/we_n) held low per access; legal 1..15.
REQ-002 SHALL have parameter T_RECOVER, default 1: cycles ce_n held high between accesses; legal 1..15.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1: arbitrator-side access request.
REQ-006 SHALL have port req_ready  output  1: controller can accept a request.
REQ-007 SHALL have port req_we  input  1: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  23: word address.
REQ-009 SHALL have port req_wdata  input  16: write data.
REQ-010 SHALL have port req_be  input  2: write byte enables; bit0 = lower, bit1 = upper.
REQ-011 SHALL have port rsp_valid  output  1: one-cycle read-data-valid pulse.
REQ-012 SHALL have port rsp_rdata  output  16: read data; holds until the next read completes.
REQ-013 SHALL have port ram_a  output  23: CellularRAM address.
REQ-014 SHALL have ports ram_dq_i  input  16 / ram_dq_o  output  16 / ram_dq_oe  output  1: split tri-state data bus.
REQ-015 SHALL have ports ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_adv_n  output  1 each: active-low RAM controls.
REQ-016 SHALL have ports stat_rd_count, stat_wr_count  output  32: completed access counters (REQ-030).

Function
REQ-017 SHALL implement FSM IDLE -> SETUP (1 cycle) -> ACCESS (T_ACCESS cycles) -> HOLD (1 cycle) -> RECOVER (T_RECOVER cycles) -> IDLE.
REQ-018 SHALL assert req_ready only in IDLE; a handshake is req_valid & req_ready at a rising edge, which latches we/addr/wdata/be and enters SETUP.
REQ-019 SHALL ignore req_valid outside IDLE; inputs may change freely after acceptance.
REQ-020 SHALL drive ram_ce_n = 0 in SETUP, ACCESS, HOLD; 1 in IDLE, RECOVER; ram_adv_n constant 0 (asynchronous mode).
REQ-021 SHALL drive ram_oe_n = 0 only in ACCESS of a read; ram_we_n = 0 only in ACCESS of a write.
REQ-022 SHALL drive ram_dq_oe = 1 in SETUP, ACCESS, HOLD of a write only, with ram_dq_o = latched wdata; ram_dq_oe = 0 in every read-cycle state, IDLE and RECOVER.
REQ-023 SHALL drive ram_lb_n = ~be[0], ram_ub_n = ~be[1] for writes and both 0 for reads, from SETUP through HOLD; both 1 otherwise.
REQ-024 SHALL hold ram_a at the latched address from SETUP through HOLD.
REQ-025 SHALL capture ram_dq_i into rsp_rdata on the edge ending the last ACCESS cycle of a read; rsp_valid = 1 for exactly the HOLD cycle of a read.
REQ-026 SHALL give read latency: handshake in cycle 0 -> rsp_valid in cycle 2+T_ACCESS (cycle 9 at default); back-to-back period 3+T_ACCESS+T_RECOVER cycles (11 at default).
REQ-027 SHALL perform a full bus cycle for a write with be = 0 (lb_n = ub_n = 1 throughout); counted as a write.
REQ-028 SHALL use a 4-bit down-counter for ACCESS/RECOVER timing; no address increment or wrap occurs (one word per request).

Reset
REQ-029 SHALL, on reset (including mid-access), enter IDLE at the next edge: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, ram_a = 0, ram_dq_o = 0, ram_dq_oe = 0, ce_n/oe_n/we_n/lb_n/ub_n = 1, counters = 0; an interrupted access produces no rsp_valid and no count.

Configuration
REQ-030 SHALL, with CELLRAM_CTRL_STATS_EN defined, increment stat_rd_count / stat_wr_count by 1 on the HOLD cycle of each read / write, wrapping 0xFFFFFFFF -> 0; without it, both outputs SHALL be constant 0 and no counter registers SHALL exist.

Structure
REQ-031 SHALL place the state enumeration, address/data widths (23/16) and default timing constants in shared package cellram_pkg.
REQ-032 SHALL use one sub-module, cellram_wait_counter (load/decrement/zero-flag 4-bit counter), for ACCESS and RECOVER durations.

Verification
REQ-033 SHALL cover: read addr 0x000123, model returns 0xBEEF -> oe_n low cycles 2..8, rsp_valid only in cycle 9, rsp_rdata = 0xBEEF.
REQ-034 SHALL cover: write addr 0x7FFFFF data 0x1234 be = 2'b10 -> we_n low 7 cycles, ub_n = 0, lb_n = 1, dq_oe high cycles 1..9, model upper byte = 0x12 only.
REQ-035 SHALL cover: req_valid held high continuously with alternating read/write -> acceptances exactly 11 cycles apart, no ce_n overlap, ce_n high ≥ 1 cycle between.
REQ-036 SHALL cover: reset asserted on cycle 4 of a write -> next edge all strobes 1, dq_oe 0, req_ready 1, no rsp_valid, counters 0.
REQ-037 SHALL cover: T_ACCESS = 1, T_RECOVER = 15 -> read rsp_valid in cycle 3, period 19 cycles.
REQ-038 SHALL cover: with CELLRAM_CTRL_STATS_EN, 3 reads + 2 writes -> stat_rd_count = 3, stat_wr_count = 2; without the macro, both 0.
